// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - switch synchroniser, debounce FSM and registered edge pulses
module switch_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_MAX   = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic SW_IN,
    output logic Q,
    output logic RISE,
    output logic FALL,
    output logic BUSY
);

    localparam int CW = (COUNT_MAX < 1) ? 1 : $clog2(COUNT_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(COUNT_MAX);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_HIGH    = 2'd2,
        ST_WAIT_LO = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   q_q, q_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], SW_IN};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // A new level is accepted only after COUNT_MAX+1 consecutive agreeing samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LOW: begin
                q_d = 1'b0;
                if (s) begin
                    state_d = ST_WAIT_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_WAIT_HI: begin
                if (!s) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    q_d     = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                q_d = 1'b1;
                if (!s) begin
                    state_d = ST_WAIT_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_WAIT_LO: begin
                if (s) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    q_d     = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
                q_d     = 1'b0;
            end
        endcase
    end

    assign Q    = q_q;
    assign RISE = rise_q;
    assign FALL = fall_q;
    assign BUSY = (state_q == ST_WAIT_HI) || (state_q == ST_WAIT_LO);

endmodule

// File: tb/tb_switch_debounce.sv
// tb/tb_switch_debounce.sv - randomized and directed bench for switch_debounce against a run-length model
`timescale 1ps/1ps
module tb_switch_debounce;

    logic CLK = 1'b0;
    logic RESET;
    logic SW_IN;
    logic q0, r0, f0, b0;
    logic q1, r1, f1, b1;

    always #50 CLK = ~CLK;

    switch_debounce #(.SYNC_STAGES(2), .COUNT_MAX(4)) dut0 (
        .CLK(CLK), .RESET(RESET), .SW_IN(SW_IN),
        .Q(q0), .RISE(r0), .FALL(f0), .BUSY(b0)
    );

    switch_debounce #(.SYNC_STAGES(2), .COUNT_MAX(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .SW_IN(SW_IN),
        .Q(q1), .RISE(r1), .FALL(f1), .BUSY(b1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: the debouncer sees SW_IN two edges late, and flips its level after
    // a run of cmax+1 consecutive samples that disagree with the current level.
    logic m_pipe[$];
    int   cmax [2] = '{4, 1};
    int   m_run [2];
    logic m_q [2];
    logic m_rise [2];
    logic m_fall [2];

    task automatic model_reset();
        m_pipe.delete();
        m_pipe.push_back(1'b0);
        m_pipe.push_back(1'b0);
        for (int i = 0; i < 2; i++) begin
            m_run[i]  = 0;
            m_q[i]    = 1'b0;
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic sw);
        logic s;
        m_pipe.push_back(sw);
        s = m_pipe.pop_front();
        for (int i = 0; i < 2; i++) begin
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            if (s != m_q[i]) begin
                m_run[i]++;
                if (m_run[i] == cmax[i] + 1) begin
                    m_q[i]    = s;
                    m_rise[i] = s;
                    m_fall[i] = !s;
                    m_run[i]  = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_q0"}, q0, m_q[0]);
        chk({tag, "_rise0"}, r0, m_rise[0]);
        chk({tag, "_fall0"}, f0, m_fall[0]);
        chk({tag, "_busy0"}, b0, m_run[0] > 0);
        chk({tag, "_q1"}, q1, m_q[1]);
        chk({tag, "_rise1"}, r1, m_rise[1]);
        chk({tag, "_fall1"}, f1, m_fall[1]);
        chk({tag, "_busy1"}, b1, m_run[1] > 0);
    endtask

    task automatic step(input logic sw);
        @(negedge CLK);
        SW_IN = sw;
        @(posedge CLK);
        if (RESET) model_reset();
        else model_edge(sw);
        #1;
        check_all("step");
    endtask

    task automatic async_reset_pulse();
        #20 RESET = 1'b1;
        #5;
        model_reset();
        check_all("arst");
        #15 RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        SW_IN = 1'b1;
        model_reset();
        #10;
        check_all("rst0");
        for (int e = 0; e < 3; e++) step(1'b1);
        #20 RESET = 1'b0;

        for (int e = 0; e < 8; e++) step(1'b0);

        // clean press
        for (int e = 0; e < 9; e++) begin
            step(1'b1);
            chk("t2_busy", b0, e >= 2 && e <= 5);
            chk("t2_q", q0, e >= 6);
            chk("t2_rise", r0, e == 6);
            chk("t2_fall", f0, 1'b0);
            chk("t6_q1", q1, e >= 3);
        end

        // clean release
        for (int e = 0; e < 9; e++) begin
            step(1'b0);
            chk("t4_q", q0, e < 6);
            chk("t4_fall", f0, e == 6);
        end

        // bounce shorter than the acceptance window
        for (int e = 0; e < 9; e++) begin
            step(e <= 2);
            chk("t3_busy", b0, e >= 2 && e <= 4);
            chk("t3_q", q0, 1'b0);
            chk("t3_rise", r0, 1'b0);
        end
        for (int e = 0; e < 6; e++) step(1'b0);

        // single-cycle glitch on the short-window instance
        step(1'b1);
        for (int e = 0; e < 6; e++) begin
            step(1'b0);
            chk("t6_rise1", r1, 1'b0);
            chk("t6_q1g", q1, 1'b0);
        end

        // async reset in the middle of a wait
        for (int e = 0; e < 4; e++) begin
            step(1'b1);
            chk("t5_busy_pre", b0, e >= 2);
        end
        #20 RESET = 1'b1;
        #5;
        model_reset();
        chk("t5_busy_in", b0, 1'b0);
        check_all("t5_arst");
        #15 RESET = 1'b0;
        for (int e = 0; e < 8; e++) begin
            step(1'b1);
            chk("t5_q", q0, e >= 6);
        end

        // random bounce patterns with occasional async resets
        for (int k = 0; k < 300; k++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++) step(lvl);
            if ($urandom_range(0, 19) == 0) async_reset_pulse();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
